// File: rtl/ps2_frame_rx_pkg.sv
// kbd_pkg: shared types and constants for the PS/2 keyboard receive path.
//   rx_state_t      - frame receiver FSM states
//   KBD_BREAK_CODE  - scan-code prefix announcing a key release
//   KBD_EXT_CODE    - scan-code prefix announcing an extended key
//   KBD_DATA_BITS   - payload bits per PS/2 frame
package kbd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic [7:0] KBD_BREAK_CODE = 8'hF0;
    localparam logic [7:0] KBD_EXT_CODE   = 8'hE0;
    localparam int         KBD_DATA_BITS  = 8;

endpackage

// File: rtl/ps2_fall_det.sv
// ps2_fall_det: falling-edge detector for an already-debounced PS/2 line.
//   clk   - system clock
//   reset - asynchronous, active-high reset
//   in    - filtered line level
//   fall  - combinational, high in the cycle the line is first seen low
// The previous-level register resets to 1 because PS/2 lines idle high,
// so leaving reset never produces a false edge.
module ps2_fall_det (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic fall
);

    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev <= 1'b1;
        else       prev <= in;
    end

    assign fall = prev & ~in;

endmodule

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 keyboard frame receiver.
// Shifts in start, 8 data bits (LSB first), odd parity and stop on each
// falling edge of the filtered PS/2 clock, then reports one outcome per
// frame as a registered one-cycle strobe.
//   clk, reset    - system clock, asynchronous active-high reset
//   kbd_clk_filt  - debounced PS/2 clock line
//   kbd_dat_filt  - debounced PS/2 data line
//   dout          - last good byte (held until the next good frame)
//   dout_new      - one-cycle strobe, dout updated
//   parity_err    - one-cycle strobe, parity failure
//   frame_err     - one-cycle strobe, bad stop bit or inter-edge timeout
//   is_break      - break-prefix flag, qualified by dout_new
//   is_ext        - extended-prefix flag, qualified by dout_new
// Build option: define KBD_BREAK_DECODE_EN to absorb F0/E0 prefix bytes
// and report them through is_break/is_ext on the following byte. Without
// it every good byte is delivered and both flags are tied low.
module ps2_frame_rx
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kbd_clk_filt,
    input  logic       kbd_dat_filt,
    output logic [7:0] dout,
    output logic       dout_new,
    output logic       parity_err,
    output logic       frame_err,
    output logic       is_break,
    output logic       is_ext
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    // Timeout fires on the edge where the counter becomes TIMEOUT_CYCLES-1.
    localparam logic [TO_W-1:0] TO_PRE = TO_W'(TIMEOUT_CYCLES - 2);

    rx_state_t                  state, state_n;
    logic [KBD_DATA_BITS-1:0]   shift, shift_n;
    logic [2:0]                 bit_cnt, bit_cnt_n;
    logic                       par, par_n;
    logic [TO_W-1:0]            to_cnt;
    logic                       fall, to_hit;
    logic                       good, perr, ferr;

    ps2_fall_det u_clk_fall (
        .clk   (clk),
        .reset (reset),
        .in    (kbd_clk_filt),
        .fall  (fall)
    );

    // A fall in the terminal cycle wins: the edge is still valid.
    assign to_hit = (state != IDLE) && !fall && (to_cnt == TO_PRE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
            to_cnt  <= '0;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            bit_cnt <= bit_cnt_n;
            par     <= par_n;
            to_cnt  <= (fall || state == IDLE) ? '0 : to_cnt + TO_W'(1);
        end
    end

    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_cnt_n = bit_cnt;
        par_n     = par;
        good      = 1'b0;
        perr      = 1'b0;
        ferr      = 1'b0;
        case (state)
            IDLE: begin
                // A high data bit on a fall is not a start bit; drop it.
                if (fall && !kbd_dat_filt) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_n   = {kbd_dat_filt, shift[KBD_DATA_BITS-1:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'(KBD_DATA_BITS - 1)) begin
                        state_n   = PARITY;
                        bit_cnt_n = '0;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_n   = kbd_dat_filt;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_n = IDLE;
                    // Stop-bit error outranks parity; odd parity means the
                    // nine bits must XOR to 1.
                    if (!kbd_dat_filt)     ferr = 1'b1;
                    else if (!(^{shift, par})) perr = 1'b1;
                    else                   good = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (to_hit) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            ferr      = 1'b1;
        end
    end

`ifdef KBD_BREAK_DECODE_EN
    logic brk_pend, ext_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout       <= '0;
            dout_new   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            is_break   <= 1'b0;
            is_ext     <= 1'b0;
            brk_pend   <= 1'b0;
            ext_pend   <= 1'b0;
        end else begin
            dout_new   <= 1'b0;
            is_break   <= 1'b0;
            is_ext     <= 1'b0;
            parity_err <= perr;
            frame_err  <= ferr;
            if (perr || ferr) begin
                // A corrupted sequence must not tag the next byte.
                brk_pend <= 1'b0;
                ext_pend <= 1'b0;
            end else if (good) begin
                if (shift == KBD_BREAK_CODE) begin
                    brk_pend <= 1'b1;
                end else if (shift == KBD_EXT_CODE) begin
                    ext_pend <= 1'b1;
                end else begin
                    dout     <= shift;
                    dout_new <= 1'b1;
                    is_break <= brk_pend;
                    is_ext   <= ext_pend;
                    brk_pend <= 1'b0;
                    ext_pend <= 1'b0;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout       <= '0;
            dout_new   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            dout_new   <= good;
            parity_err <= perr;
            frame_err  <= ferr;
            if (good) dout <= shift;
        end
    end

    assign is_break = 1'b0;
    assign is_ext   = 1'b0;
`endif

endmodule
